// File: rtl/elastic_buf.sv
// elastic_buf: registered FIFO buffer with valid/ready on both sides.
// First-word-fall-through output; all status derives from registered state.
module elastic_buf #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] I,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] O,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [AW:0]      COUNT
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [AW:0]                 count_q, count_d;
  logic                        push, pop;

  // Status outputs come straight from registers; reset gates IN_READY low.
  always_comb begin
    IN_READY  = RESET_N & (count_q != FULL_CNT);
    OUT_VALID = (count_q != '0);
    O         = mem_q[rd_ptr_q];
    COUNT     = count_q;
  end

  // Next-state: handshakes update pointers/count; FLUSH discards everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push     = IN_VALID & IN_READY;
    pop      = OUT_VALID & OUT_READY;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = I;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      // push and pop together leave the occupancy unchanged
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State register with synchronous active-low reset clearing storage too.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
